// File: rtl/fadd_rr_sched.sv
// Round-robin scheduler sharing one pipelined fadd unit among NREQ requesters.
// Each issue carries a requester tag through a LAT-deep pipe so results route back to their owner.
module fadd_rr_sched #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*N-1:0] req_op1,
  input  logic [NREQ*N-1:0] req_op2,
  output logic [NREQ-1:0]   resp_val,
  output logic [N-1:0]      resp_res,
  output logic              fadd_en,
  output logic [N-1:0]      fadd_op1,
  output logic [N-1:0]      fadd_op2,
  input  logic              fadd_res_val,
  input  logic [N-1:0]      fadd_res,
  output logic              busy,
  output logic              err
);
  localparam int TW = $clog2(NREQ);

  logic [TW-1:0]  ptr_reg;
  logic [TW-1:0]  fadd_tag_reg;
  logic [TW-1:0]  grant_idx;
  logic           grant_any;
  logic [LAT-1:0] slot_v_reg;
  logic [TW-1:0]  slot_tag_reg [LAT];
  int             idx;

  // Search starts just after the last granted requester, so the last winner has lowest priority.
  always_comb begin
    req_rdy   = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!hold && !grant_any && req_val[idx]) begin
        req_rdy[idx] = 1'b1;
        grant_idx    = TW'(idx);
        grant_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= TW'(NREQ - 1);
      fadd_en      <= 1'b0;
      fadd_op1     <= '0;
      fadd_op2     <= '0;
      fadd_tag_reg <= '0;
    end else begin
      fadd_en <= grant_any;
      if (grant_any) begin
        fadd_op1     <= req_op1[int'(grant_idx)*N +: N];
        fadd_op2     <= req_op2[int'(grant_idx)*N +: N];
        fadd_tag_reg <= grant_idx;
        ptr_reg      <= grant_idx;
      end
    end
  end

  // Slot 0 captures the op currently presented to the fadd; slot LAT-1 lines up with its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_reg[0]   <= 1'b0;
      slot_tag_reg[0] <= '0;
    end else begin
      slot_v_reg[0]   <= fadd_en;
      slot_tag_reg[0] <= fadd_tag_reg;
    end
  end

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_v_reg[gi]   <= 1'b0;
          slot_tag_reg[gi] <= '0;
        end else begin
          slot_v_reg[gi]   <= slot_v_reg[gi-1];
          slot_tag_reg[gi] <= slot_tag_reg[gi-1];
        end
      end
    end
  endgenerate

  // A result without a matching tag is dropped; any tag/result disagreement latches err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_val <= '0;
      resp_res <= '0;
      err      <= 1'b0;
    end else begin
      if (slot_v_reg[LAT-1] && fadd_res_val)
        resp_val <= NREQ'(1) << slot_tag_reg[LAT-1];
      else
        resp_val <= '0;
      if (fadd_res_val)
        resp_res <= fadd_res;
      if (slot_v_reg[LAT-1] != fadd_res_val)
        err <= 1'b1;
    end
  end

  assign busy = fadd_en | (|slot_v_reg);

endmodule
